// File: rtl/npu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npu_pkg
//  Description : Shared types and constants for the NPU output-layer blocks:
//                the arg-max sequencer state encoding, default score width,
//                default class count and the signed score type.
//  Revision    : 1.0  initial release
// ============================================================================
package npu_pkg;

    localparam int C_DATA_W    = 16;   // default score width
    localparam int C_N_CLASSES = 10;   // default number of scores scanned
    localparam int C_IDX_W     = 8;    // default address / class index width

    // Signed two's-complement score as it leaves the dense-layer accumulator.
    typedef logic signed [C_DATA_W-1:0] score_t;

    // Arg-max sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : npu_pkg
`default_nettype wire

// File: rtl/argmax_cmp_stage.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_cmp_stage
//  Description : Registered running-maximum tracker. Each valid word is
//                compared against the current best; the first word of a scan
//                loads unconditionally. Ties keep the earlier (lower) index.
//                With ARGMAX_MARGIN_EN defined, a second-best value is also
//                tracked and the best-minus-second margin is provided.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLKEXT     in   system clock, rising edge
//    RSTN_CTRL  in   asynchronous active-low reset
//    clear      in   discard tracker state (scan cancelled)
//    valid      in   data/idx carry a returning score this cycle
//    first      in   this word is index 0 of the scan
//    idx        in   index of the returning score
//    data       in   returning score (signed)
//    best_val   out  current best score
//    best_idx   out  index of current best score
//    margin     out  best - second best (ARGMAX_MARGIN_EN only)
//  Build option : ARGMAX_MARGIN_EN
// ============================================================================
module argmax_cmp_stage
    import npu_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int IDX_W  = C_IDX_W
) (
    input  logic                     CLKEXT,
    input  logic                     RSTN_CTRL,
    input  logic                     clear,
    input  logic                     valid,
    input  logic                     first,
    input  logic [IDX_W-1:0]         idx,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [DATA_W-1:0] best_val,
    output logic [IDX_W-1:0]         best_idx
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic signed [DATA_W:0]   margin
`endif
);

    logic signed [DATA_W-1:0] r_best_val;
    logic [IDX_W-1:0]         r_best_idx;
    logic                     w_new_best;

    // Strict greater-than so that an equal later score never displaces the
    // earlier one. The first word bypasses the compare entirely.
    assign w_new_best = valid && (first || (data > r_best_val));

    always_ff @(posedge CLKEXT or negedge RSTN_CTRL) begin
        if (!RSTN_CTRL) begin
            r_best_val <= '0;
            r_best_idx <= '0;
        end else if (clear) begin
            r_best_val <= '0;
            r_best_idx <= '0;
        end else if (w_new_best) begin
            r_best_val <= data;
            r_best_idx <= idx;
        end
    end

    assign best_val = r_best_val;
    assign best_idx = r_best_idx;

`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_W-1:0] r_second_val;
    logic                     w_is_second;

    // Index 1 is the first word that can seed the second-best slot: either it
    // beats index 0 (old best moves down) or it becomes second-best directly.
    assign w_is_second = (idx == IDX_W'(1));

    always_ff @(posedge CLKEXT or negedge RSTN_CTRL) begin
        if (!RSTN_CTRL) begin
            r_second_val <= '0;
        end else if (clear) begin
            r_second_val <= '0;
        end else if (valid && !first) begin
            if (w_new_best) begin
                r_second_val <= r_best_val;
            end else if (w_is_second || (data > r_second_val)) begin
                r_second_val <= data;
            end
        end
    end

    // Sign-extend both operands by one bit so the difference never overflows.
    assign margin = {r_best_val[DATA_W-1], r_best_val}
                  - {r_second_val[DATA_W-1], r_second_val};
`endif

endmodule : argmax_cmp_stage
`default_nettype wire

// File: rtl/argmax_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_sequencer
//  Description : Output-layer arg-max controller. On START it reads
//                N_CLASSES scores from the score buffer (one address per
//                cycle), tracks the running maximum one cycle behind the
//                read address, and reports the winning class index and score
//                with a one-cycle DONE pulse. Results are held until the next
//                DONE or reset; ABORT cancels a scan and keeps the old result.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLKEXT       in   system clock, rising edge
//    RSTN_CTRL    in   asynchronous active-low reset
//    START        in   begin a scan (sampled only in IDLE)
//    ABORT        in   cancel an in-progress scan
//    RD_EN        out  score buffer read strobe
//    RD_ADDR      out  score buffer address
//    RD_DATA      in   score, valid one cycle after RD_EN/RD_ADDR
//    BUSY         out  scan in progress (through the DONE cycle)
//    DONE         out  one-cycle pulse, result valid
//    CLASS_IDX    out  index of maximum score
//    CLASS_SCORE  out  maximum score
//    MARGIN       out  best - second best (ARGMAX_MARGIN_EN only)
//  Build option : ARGMAX_MARGIN_EN
// ============================================================================
module argmax_sequencer
    import npu_pkg::*;
#(
    parameter int N_CLASSES = C_N_CLASSES,
    parameter int DATA_W    = C_DATA_W,
    parameter int IDX_W     = C_IDX_W
) (
    input  logic                     CLKEXT,
    input  logic                     RSTN_CTRL,
    input  logic                     START,
    input  logic                     ABORT,
    output logic                     RD_EN,
    output logic [IDX_W-1:0]         RD_ADDR,
    input  logic signed [DATA_W-1:0] RD_DATA,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [IDX_W-1:0]         CLASS_IDX,
    output logic signed [DATA_W-1:0] CLASS_SCORE
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic signed [DATA_W:0]   MARGIN
`endif
);

    localparam logic [IDX_W-1:0] C_LAST_ADDR = IDX_W'(N_CLASSES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_addr;
    logic             w_abort;
    logic             w_start_ok;

    // Returning-word pipeline: one cycle behind the read request.
    logic             r_vld;
    logic             r_first;
    logic [IDX_W-1:0] r_idx;

    logic signed [DATA_W-1:0] w_best_val;
    logic [IDX_W-1:0]         w_best_idx;
    logic signed [DATA_W-1:0] r_hold_score;
    logic [IDX_W-1:0]         r_hold_idx;

    assign w_abort    = ABORT && (r_state != ST_IDLE);
    assign w_start_ok = START && (r_state == ST_IDLE);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge CLKEXT or negedge RSTN_CTRL) begin
        if (!RSTN_CTRL) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (START) w_state_nxt = ST_FETCH;
            ST_FETCH: if (r_addr == C_LAST_ADDR) w_state_nxt = ST_DRAIN;
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        // Cancellation wins over every other transition, including START.
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // --------------------------------------------------------- address counter
    // Holds at the last address once reached so RD_ADDR stays in range.
    always_ff @(posedge CLKEXT or negedge RSTN_CTRL) begin
        if (!RSTN_CTRL) begin
            r_addr <= '0;
        end else if (w_start_ok) begin
            r_addr <= '0;
        end else if ((r_state == ST_FETCH) && (r_addr != C_LAST_ADDR)) begin
            r_addr <= r_addr + IDX_W'(1);
        end
    end

    assign RD_EN   = (r_state == ST_FETCH);
    assign RD_ADDR = r_addr;
    assign BUSY    = (r_state != ST_IDLE);
    assign DONE    = (r_state == ST_DONE);

    // ------------------------------------------------------ return pipeline
    always_ff @(posedge CLKEXT or negedge RSTN_CTRL) begin
        if (!RSTN_CTRL) begin
            r_vld   <= 1'b0;
            r_first <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_vld   <= RD_EN && !w_abort;
            r_first <= (r_addr == '0);
            r_idx   <= r_addr;
        end
    end

    // --------------------------------------------------------- compare stage
`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_W:0] w_margin;
    logic signed [DATA_W:0] r_hold_margin;
`endif

    argmax_cmp_stage #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .CLKEXT    (CLKEXT),
        .RSTN_CTRL (RSTN_CTRL),
        .clear     (w_abort),
        .valid     (r_vld),
        .first     (r_first),
        .idx       (r_idx),
        .data      (RD_DATA),
        .best_val  (w_best_val),
        .best_idx  (w_best_idx)
`ifdef ARGMAX_MARGIN_EN
        ,
        .margin    (w_margin)
`endif
    );

    // ------------------------------------------------------- result holding
    // The tracker already holds the final result during the DONE cycle, so it
    // is shown directly then and copied into the hold registers at the end of
    // that cycle. Outside DONE the held copy is shown, which is why an
    // aborted scan never disturbs the previous result.
    always_ff @(posedge CLKEXT or negedge RSTN_CTRL) begin
        if (!RSTN_CTRL) begin
            r_hold_idx   <= '0;
            r_hold_score <= '0;
        end else if (r_state == ST_DONE) begin
            r_hold_idx   <= w_best_idx;
            r_hold_score <= w_best_val;
        end
    end

    assign CLASS_IDX   = (r_state == ST_DONE) ? w_best_idx : r_hold_idx;
    assign CLASS_SCORE = (r_state == ST_DONE) ? w_best_val : r_hold_score;

`ifdef ARGMAX_MARGIN_EN
    always_ff @(posedge CLKEXT or negedge RSTN_CTRL) begin
        if (!RSTN_CTRL) begin
            r_hold_margin <= '0;
        end else if (r_state == ST_DONE) begin
            r_hold_margin <= w_margin;
        end
    end

    assign MARGIN = (r_state == ST_DONE) ? w_margin : r_hold_margin;
`endif

endmodule : argmax_sequencer
`default_nettype wire

// File: tb/tb_argmax_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_argmax_sequencer
//  Description : Self-checking bench for argmax_sequencer. Directed score
//                sets plus randomized ones are checked against a reference
//                that computes the arg-max directly from the score array.
//  Revision    : 1.0  initial release
//  Build option : ARGMAX_MARGIN_EN (adds MARGIN checks)
// ============================================================================
module tb_argmax_sequencer;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int IW = 8;

    logic                 CLKEXT;
    logic                 RSTN_CTRL;
    logic                 START;
    logic                 ABORT;
    logic                 RD_EN;
    logic [IW-1:0]        RD_ADDR;
    logic signed [DW-1:0] RD_DATA;
    logic                 BUSY;
    logic                 DONE;
    logic [IW-1:0]        CLASS_IDX;
    logic signed [DW-1:0] CLASS_SCORE;
`ifdef ARGMAX_MARGIN_EN
    logic signed [DW:0]   MARGIN;
`endif

    argmax_sequencer #(
        .N_CLASSES (N),
        .DATA_W    (DW),
        .IDX_W     (IW)
    ) dut (
        .CLKEXT      (CLKEXT),
        .RSTN_CTRL   (RSTN_CTRL),
        .START       (START),
        .ABORT       (ABORT),
        .RD_EN       (RD_EN),
        .RD_ADDR     (RD_ADDR),
        .RD_DATA     (RD_DATA),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .CLASS_IDX   (CLASS_IDX),
        .CLASS_SCORE (CLASS_SCORE)
`ifdef ARGMAX_MARGIN_EN
        ,
        .MARGIN      (MARGIN)
`endif
    );

    initial CLKEXT = 1'b0;
    always #5 CLKEXT = ~CLKEXT;

    // Score buffer: one-cycle read latency.
    logic signed [DW-1:0] mem [N];
    always @(posedge CLKEXT) begin
        if (RD_EN && (int'(RD_ADDR) < N)) RD_DATA <= mem[RD_ADDR];
    end

    int n_vec;
    int n_err;
    // Last result the DUT should be holding.
    int m_idx;
    int m_score;
    int m_margin;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: lowest index holding the maximum; margin is the maximum minus
    // the largest of the remaining entries (duplicates count).
    task automatic ref_model(output int bi, output int bs, output int mg);
        int sec;
        bi = 0;
        for (int i = 1; i < N; i++) if (int'(mem[i]) > int'(mem[bi])) bi = i;
        bs  = int'(mem[bi]);
        sec = -1000000;
        for (int i = 0; i < N; i++) if (i != bi && int'(mem[i]) > sec) sec = int'(mem[i]);
        mg = bs - sec;
    endtask

    task automatic chk_result(input string tag, input int ei, input int es, input int em);
        chk({tag, "_idx"}, 32'(CLASS_IDX), 32'(ei));
        chk({tag, "_score"}, 32'(CLASS_SCORE), 32'(es));
`ifdef ARGMAX_MARGIN_EN
        chk({tag, "_margin"}, 32'(MARGIN), 32'(em));
`else
        if (em != em) n_err++;
`endif
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_rden"}, 32'(RD_EN), 0);
        chk({tag, "_addr"}, 32'(RD_ADDR), 0);
        chk({tag, "_busy"}, 32'(BUSY), 0);
        chk({tag, "_done"}, 32'(DONE), 0);
        chk_result(tag, 0, 0, 0);
    endtask

    // One scan. abort_at / reset_at / pulse_at select a read index at which
    // ABORT is raised, reset is applied, or START is pulsed (-1 = never).
    task automatic do_scan(input string tag, input int abort_at,
                           input int reset_at, input int pulse_at);
        int ei, es, em, dcnt;
        ref_model(ei, es, em);
        START = 1'b1;
        @(negedge CLKEXT);
        START = 1'b0;
        chk({tag, "_busy_e0"}, 32'(BUSY), 1);
        for (int k = 0; k < N; k++) begin
            if (k == abort_at) begin
                ABORT = 1'b1;
                @(negedge CLKEXT);
                ABORT = 1'b0;
                chk({tag, "_abort_busy"}, 32'(BUSY), 0);
                chk({tag, "_abort_rden"}, 32'(RD_EN), 0);
                dcnt = 0;
                repeat (N + 4) begin
                    if (DONE) dcnt++;
                    @(negedge CLKEXT);
                end
                chk({tag, "_abort_nodone"}, 32'(dcnt), 0);
                chk_result({tag, "_abort_keep"}, m_idx, m_score, m_margin);
                return;
            end
            if (k == reset_at) begin
                RSTN_CTRL = 1'b0;
                #1;
                chk_zero_outputs({tag, "_rst"});
                m_idx = 0; m_score = 0; m_margin = 0;
                @(negedge CLKEXT);
                RSTN_CTRL = 1'b1;
                @(negedge CLKEXT);
                chk_zero_outputs({tag, "_rst_rel"});
                return;
            end
            chk({tag, "_rden"}, 32'(RD_EN), 1);
            chk({tag, "_addr"}, 32'(RD_ADDR), 32'(k));
            if (k == pulse_at) START = 1'b1;
            @(negedge CLKEXT);
            START = 1'b0;
        end
        chk({tag, "_drain_rden"}, 32'(RD_EN), 0);
        chk({tag, "_drain_done"}, 32'(DONE), 0);
        @(negedge CLKEXT);
        chk({tag, "_done"}, 32'(DONE), 1);
        chk({tag, "_done_busy"}, 32'(BUSY), 1);
        chk_result(tag, ei, es, em);
        m_idx = ei; m_score = es; m_margin = em;
        @(negedge CLKEXT);
        chk({tag, "_post_busy"}, 32'(BUSY), 0);
        dcnt = 0;
        repeat (N + 3) begin
            if (DONE) dcnt++;
            @(negedge CLKEXT);
        end
        chk({tag, "_single_done"}, 32'(dcnt), 0);
        chk_result({tag, "_hold"}, m_idx, m_score, m_margin);
    endtask

    task automatic load(input int v0, input int v1, input int v2, input int v3, input int v4,
                        input int v5, input int v6, input int v7, input int v8, input int v9);
        int v [10];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8, v9};
        for (int i = 0; i < N; i++) mem[i] = DW'(v[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, ei, es, em;
        n_vec = 0; n_err = 0;
        m_idx = 0; m_score = 0; m_margin = 0;
        RSTN_CTRL = 1'b0;
        START     = 1'b0;
        ABORT     = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (2) @(negedge CLKEXT);
        chk_zero_outputs("reset");
        RSTN_CTRL = 1'b1;
        @(negedge CLKEXT);
        chk_zero_outputs("reset_rel");

        // Directed cases; the reference is cross-checked against the
        // hand-computed answers where the scenario states them.
        load(100, 200, 300, 150, 50, 0, 10, 20, 30, 40);
        ref_model(ei, es, em);
        chk("basic_ref_idx", 32'(ei), 2);
        do_scan("basic", -1, -1, -1);
        chk_result("basic_exp", 2, 300, 100);

        load(32'h8001, 32'h8003, 32'h8002, 32'h8000, 32'h8001,
             32'h8002, 32'h8000, 32'h8001, 32'h8002, 32'h8000);
        do_scan("neg", -1, -1, -1);
        chk_result("neg_exp", 1, int'(16'sh8003), 1);

        load(0, 0, 0, 500, 0, 0, 0, 500, 0, 0);
        do_scan("tie", -1, -1, -1);
        chk_result("tie_exp", 3, 500, 0);

        load(10, -20, 300, 290, 0, 0, 0, 0, 0, 0);
        do_scan("margin", -1, -1, -1);
        chk_result("margin_exp", 2, 300, 10);

        // Abort at address 4 with different data; old result must survive.
        load(1, 2, 3, 4, 5000, 6, 7, 8, 9, 10);
        do_scan("abort", 4, -1, -1);
        do_scan("after_abort", -1, -1, -1);

        // START pulsed while busy: ignored, one DONE only.
        load(-5, 7, 7, -100, 3, 7, 0, 1, 2, 6);
        do_scan("pulse", -1, -1, 3);

        // Reset in the middle of FETCH.
        do_scan("rst_mid", -1, 5, -1);

        // START held high: IDLE for one cycle after DONE, then a new scan.
        load(9, 8, 7, 6, 5, 4, 3, 2, 1, 0);
        ref_model(ei, es, em);
        START = 1'b1;
        @(negedge CLKEXT);
        cyc = 0;
        while (!DONE && cyc < 40) begin
            @(negedge CLKEXT);
            cyc++;
        end
        chk("b2b_latency1", 32'(cyc), 32'(N + 1));
        chk_result("b2b_1", ei, es, em);
        @(negedge CLKEXT);
        chk("b2b_idle_busy", 32'(BUSY), 0);
        @(negedge CLKEXT);
        chk("b2b_restart_rden", 32'(RD_EN), 1);
        chk("b2b_restart_addr", 32'(RD_ADDR), 0);
        START = 1'b0;
        cyc = 0;
        while (!DONE && cyc < 40) begin
            @(negedge CLKEXT);
            cyc++;
        end
        chk("b2b_latency2", 32'(cyc), 32'(N + 1));
        chk_result("b2b_2", ei, es, em);
        m_idx = ei; m_score = es; m_margin = em;
        @(negedge CLKEXT);
        chk("b2b_end_done", 32'(DONE), 0);

        // Randomized score sets; narrow ranges force ties and duplicates.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < N; i++) begin
                case (t % 3)
                    0:       mem[i] = DW'($urandom);
                    1:       mem[i] = DW'($urandom_range(0, 3));
                    default: mem[i] = DW'(int'($urandom_range(0, 4)) - 3);
                endcase
            end
            do_scan("rand", -1, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_argmax_sequencer
`default_nettype wire
